// File: rtl/edge_interval_timer.sv
// rtl/edge_interval_timer.sv - cycle count between successive edge pulses
// Each measured interval goes to a 1-deep valid/ready register; losses from back-pressure set a sticky flag.
module edge_interval_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  input  logic             enable,
  output logic [WIDTH-1:0] interval,
  output logic             valid,
  input  logic             ready,
  output logic             overrun,
  input  logic             clear_overrun
);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_next;
  logic             capture;
  logic             load;
  logic             drop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable && in) state_next = COUNT;
      COUNT:   if (!enable) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The pulse that closes one interval also opens the next, so cnt restarts at 1.
  always_comb begin
    cnt_next = '0;
    capture  = 1'b0;
    case (state)
      IDLE: begin
        if (enable && in) cnt_next = CNT_ONE;
      end
      COUNT: begin
        if (enable) begin
          if (in) begin
            capture  = 1'b1;
            cnt_next = CNT_ONE;
          end else if (cnt == CNT_MAX) begin
            cnt_next = cnt;
          end else begin
            cnt_next = cnt + CNT_ONE;
          end
        end
      end
      default: ;
    endcase
    load = capture && (!valid || ready);
    drop = capture && valid && !ready;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end

  // A load may coincide with a transfer; valid then stays high with the new sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      interval <= '0;
      valid    <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (load) begin
        interval <= cnt;
        valid    <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
      if (drop) begin
        overrun <= 1'b1;
      end else if (clear_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_edge_interval_timer.sv
// tb/tb_edge_interval_timer.sv - self-checking bench for edge_interval_timer
// Two widths share stimulus; a timestamp model predicts outputs every cycle.
module tb_edge_interval_timer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pulse = 1'b0;
  logic        enable = 1'b0;
  logic        ready = 1'b0;
  logic        clear_overrun = 1'b0;
  logic [15:0] interval16;
  logic        valid16;
  logic        overrun16;
  logic [3:0]  interval4;
  logic        valid4;
  logic        overrun4;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  edge_interval_timer #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .in(pulse), .enable(enable),
    .interval(interval16), .valid(valid16), .ready(ready),
    .overrun(overrun16), .clear_overrun(clear_overrun)
  );

  edge_interval_timer #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .in(pulse), .enable(enable),
    .interval(interval4), .valid(valid4), .ready(ready),
    .overrun(overrun4), .clear_overrun(clear_overrun)
  );

  // Model: timestamp of the last arming pulse, interval = now - then, clipped.
  longint cyc = 0;
  longint last_t [2] = '{0, 0};
  longint mx     [2] = '{65535, 15};
  longint mi     [2] = '{0, 0};
  bit     armed  [2] = '{0, 0};
  bit     mv     [2] = '{0, 0};
  bit     mo     [2] = '{0, 0};

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < 2; j++) begin
        armed[j] = 0; mv[j] = 0; mi[j] = 0; mo[j] = 0;
      end
    end else begin
      cyc = cyc + 1;
      for (int j = 0; j < 2; j++) begin
        bit     cap;
        bit     dropped;
        longint sample;
        cap     = armed[j] && enable && pulse;
        sample  = cyc - last_t[j];
        if (sample > mx[j]) sample = mx[j];
        dropped = cap && mv[j] && !ready;
        if (cap && !dropped) begin
          mi[j] = sample;
          mv[j] = 1;
        end else if (mv[j] && ready) begin
          mv[j] = 0;
        end
        if (dropped) mo[j] = 1;
        else if (clear_overrun) mo[j] = 0;
        if (!enable) armed[j] = 0;
        else if (pulse) begin
          armed[j]  = 1;
          last_t[j] = cyc;
        end
      end
    end
  end

  task automatic chk(input string name, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
  endtask

  always @(negedge clk) begin
    chk("cmp16_interval", longint'(interval16), mi[0]);
    chk("cmp16_valid",    longint'(valid16),    longint'(mv[0]));
    chk("cmp16_overrun",  longint'(overrun16),  longint'(mo[0]));
    chk("cmp4_interval",  longint'(interval4),  mi[1]);
    chk("cmp4_valid",     longint'(valid4),     longint'(mv[1]));
    chk("cmp4_overrun",   longint'(overrun4),   longint'(mo[1]));
  end

  // Inputs set here are sampled at the following rising edge.
  task automatic drive(input bit i, input bit e, input bit r, input bit c);
    @(posedge clk);
    #2;
    pulse = i; enable = e; ready = r; clear_overrun = c;
  endtask

  initial begin
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    chk("reset_interval", longint'(interval16), 0);
    chk("reset_valid",    longint'(valid16),    0);
    chk("reset_overrun",  longint'(overrun16),  0);

    // Pulses every 2 cycles: first only arms, then interval 2 each time.
    for (int k = 0; k < 6; k++) begin
      drive(1, 1, 1, 0);
      drive(0, 1, 1, 0);
      if (k == 0) chk("t1_arm_valid", longint'(valid16), 0);
      else begin
        chk("t1_valid",    longint'(valid16),    1);
        chk("t1_interval", longint'(interval16), 2);
      end
    end
    chk("t1_overrun", longint'(overrun16), 0);

    // Back-to-back pulses report 1; valid lasts exactly one cycle.
    repeat (3) drive(0, 0, 1, 0);
    drive(1, 1, 1, 0);
    drive(1, 1, 1, 0);
    drive(0, 1, 1, 0);
    chk("t2_valid",    longint'(valid16),    1);
    chk("t2_interval", longint'(interval16), 1);
    drive(0, 1, 1, 0);
    chk("t2_valid_drop", longint'(valid16), 0);

    // 20-cycle spacing: saturates at 15 in the narrow instance.
    drive(1, 1, 1, 0);
    repeat (19) drive(0, 1, 1, 0);
    drive(1, 1, 1, 0);
    drive(0, 1, 1, 0);
    chk("t3_interval4",  longint'(interval4),  15);
    chk("t3_interval16", longint'(interval16), 20);
    chk("t3_valid4",     longint'(valid4),     1);

    // Back-pressure: 5 held, 7 dropped, overrun set then cleared.
    repeat (2) drive(0, 0, 1, 0);
    drive(1, 1, 0, 0);
    repeat (4) drive(0, 1, 0, 0);
    drive(1, 1, 0, 0);
    repeat (6) drive(0, 1, 0, 0);
    drive(1, 1, 0, 0);
    drive(0, 1, 0, 0);
    chk("t4_interval", longint'(interval16), 5);
    chk("t4_valid",    longint'(valid16),    1);
    chk("t4_overrun",  longint'(overrun16),  1);
    drive(0, 1, 1, 0);
    drive(0, 1, 1, 1);
    chk("t4_accept_valid",    longint'(valid16),    0);
    chk("t4_accept_interval", longint'(interval16), 5);
    chk("t4_overrun_held",    longint'(overrun16),  1);
    drive(0, 1, 1, 0);
    chk("t4_overrun_clr", longint'(overrun16), 0);

    // Accept and capture at the same edge: 3 then 4 with no bubble.
    drive(1, 1, 1, 0);
    repeat (2) drive(0, 1, 1, 0);
    drive(1, 1, 0, 0);
    drive(0, 1, 0, 0);
    chk("t5_interval3", longint'(interval16), 3);
    repeat (2) drive(0, 1, 0, 0);
    drive(1, 1, 1, 0);
    drive(0, 1, 1, 0);
    chk("t5_valid",     longint'(valid16),    1);
    chk("t5_interval4", longint'(interval16), 4);
    drive(0, 1, 1, 0);

    // Reset mid-interval at cnt=6, then re-arm.
    drive(1, 1, 1, 0);
    repeat (6) drive(0, 1, 1, 0);
    #1 reset = 1'b1;
    #1;
    chk("t6_rst_interval", longint'(interval16), 0);
    chk("t6_rst_valid",    longint'(valid16),    0);
    chk("t6_rst_overrun",  longint'(overrun16),  0);
    @(posedge clk);
    #2 reset = 1'b0;
    drive(1, 1, 1, 0);
    drive(0, 1, 1, 0);
    chk("t6_arm_valid", longint'(valid16), 0);
    repeat (2) drive(0, 1, 1, 0);
    drive(1, 1, 1, 0);
    drive(0, 1, 1, 0);
    chk("t6_interval4", longint'(interval16), 4);

    // enable=0 mid-interval abandons it; the next pair reports true spacing.
    drive(0, 1, 1, 0);
    drive(1, 0, 1, 0);
    drive(0, 0, 1, 0);
    drive(1, 1, 1, 0);
    repeat (2) drive(0, 1, 1, 0);
    drive(1, 1, 1, 0);
    drive(0, 1, 1, 0);
    chk("t6_interval3", longint'(interval16), 3);
    repeat (3) drive(0, 1, 1, 0);
    drive(1, 1, 1, 0);
    drive(0, 1, 1, 0);
    chk("t6_interval5", longint'(interval16), 5);
    repeat (3) drive(0, 0, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
